// File: rtl/ahbl_excl_monitor.sv
// Global AHB-Lite exclusive-access monitor: one reservation per master, suppresses failing exclusive writes.
// Optional: define AHBL_EXCL_MONITOR_SNOOP_EN to let plain writes clear matching reservations.
module ahbl_excl_monitor #(
  parameter int unsigned W_ADDR       = 32,
  parameter int unsigned W_DATA       = 32,
  parameter int unsigned N_MASTERS    = 2,
  parameter int unsigned GRANULE_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_hready,
  output logic              src_hready_resp,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hexcl,
  input  logic [7:0]        src_hmaster,
  output logic              src_hexokay,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam int unsigned W_GRAN = W_ADDR - GRANULE_LOG2;
  localparam int unsigned W_MID  = 8;
  localparam logic [1:0]  HTRANS_IDLE = 2'b00;

  logic              dp_valid;
  logic              dp_excl;
  logic              dp_write;
  logic [W_MID-1:0]  dp_master;
  logic [W_GRAN-1:0] dp_granule;
  logic              dp_pass;
  logic              dp_suppr;

  logic [N_MASTERS-1:0] resv_valid;
  logic [N_MASTERS-1:0] resv_valid_nxt;
  logic [W_GRAN-1:0]    resv_addr     [N_MASTERS];
  logic [W_GRAN-1:0]    resv_addr_nxt [N_MASTERS];

  logic              accept;
  logic              complete;
  logic              dp_okay;
  logic [W_GRAN-1:0] a_granule;
  logic              a_master_ok;
  logic              a_pass;
  logic              a_suppr;

  assign accept      = src_hready && src_htrans[1];
  assign a_granule   = src_haddr[W_ADDR-1:GRANULE_LOG2];
  assign a_master_ok = src_hmaster < W_MID'(N_MASTERS);

  // Data-phase response: monitor answers suppressed writes itself, otherwise mirrors the slave
  assign src_hready_resp = !dp_valid || dp_suppr || dst_hready_resp;
  assign src_hresp       = dp_valid && !dp_suppr && dst_hresp;
  assign src_hexokay     = dp_valid && dp_excl && dp_pass && !src_hresp;
  assign src_hrdata      = dst_hrdata;
  assign complete        = dp_valid && src_hready_resp;
  assign dp_okay         = !src_hresp;

  // Reservation state as it will be after this cycle's data-phase completion
  always_comb begin
    resv_valid_nxt = resv_valid;
    resv_addr_nxt  = resv_addr;
    if (complete) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (dp_excl && !dp_write && dp_pass && dp_okay && (dp_master == W_MID'(i))) begin
          resv_valid_nxt[i] = 1'b1;
          resv_addr_nxt[i]  = dp_granule;
        end
        if (dp_excl && dp_write && (dp_master == W_MID'(i))) begin
          resv_valid_nxt[i] = 1'b0;
        end
        if (dp_excl && dp_write && dp_pass && dp_okay && (resv_addr[i] == dp_granule)) begin
          resv_valid_nxt[i] = 1'b0;
        end
`ifdef AHBL_EXCL_MONITOR_SNOOP_EN
        if (!dp_excl && dp_write && dp_okay && (resv_addr[i] == dp_granule)) begin
          resv_valid_nxt[i] = 1'b0;
        end
`endif
      end
    end
  end

  // Address-phase pass check sees the forwarded reservation state
  always_comb begin
    a_pass = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if ((src_hmaster == W_MID'(i)) && resv_valid_nxt[i] && (resv_addr_nxt[i] == a_granule)) begin
        a_pass = 1'b1;
      end
    end
  end

  assign a_suppr = src_htrans[1] && src_hexcl && src_hwrite && !a_pass;

  assign dst_hready    = src_hready;
  assign dst_haddr     = src_haddr;
  assign dst_hwrite    = src_hwrite;
  assign dst_htrans    = a_suppr ? HTRANS_IDLE : src_htrans;
  assign dst_hsize     = src_hsize;
  assign dst_hburst    = src_hburst;
  assign dst_hprot     = src_hprot;
  assign dst_hmastlock = src_hmastlock;
  assign dst_hwdata    = src_hwdata;

  // Data-phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid   <= 1'b0;
      dp_excl    <= 1'b0;
      dp_write   <= 1'b0;
      dp_master  <= '0;
      dp_granule <= '0;
      dp_pass    <= 1'b0;
      dp_suppr   <= 1'b0;
    end else if (accept) begin
      dp_valid   <= 1'b1;
      dp_excl    <= src_hexcl;
      dp_write   <= src_hwrite;
      dp_master  <= src_hmaster;
      dp_granule <= a_granule;
      dp_pass    <= src_hwrite ? a_pass : a_master_ok;
      dp_suppr   <= a_suppr;
    end else if (complete) begin
      dp_valid   <= 1'b0;
    end
  end

  // Reservation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        resv_addr[i] <= '0;
      end
    end else begin
      resv_valid <= resv_valid_nxt;
      resv_addr  <= resv_addr_nxt;
    end
  end

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Self-checking bench for ahbl_excl_monitor: directed table, reset corner, randomized stream vs transaction model.
module tb_ahbl_excl_monitor;

  localparam int unsigned W_ADDR = 32;
  localparam int unsigned W_DATA = 32;
  localparam int unsigned N_M    = 2;
  localparam int          LIMIT  = 20000;
`ifdef AHBL_EXCL_MONITOR_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              src_hready, src_hready_resp, src_hresp, src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
  logic [W_ADDR-1:0] src_haddr;
  logic [1:0]        src_htrans;
  logic [2:0]        src_hsize, src_hburst;
  logic [3:0]        src_hprot;
  logic [W_DATA-1:0] src_hwdata, src_hrdata;
  logic [7:0]        src_hmaster;
  logic              dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
  logic [W_ADDR-1:0] dst_haddr;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize, dst_hburst;
  logic [3:0]        dst_hprot;
  logic [W_DATA-1:0] dst_hwdata, dst_hrdata;

  ahbl_excl_monitor #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_MASTERS(N_M), .GRANULE_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans), .src_hsize(src_hsize),
    .src_hburst(src_hburst), .src_hprot(src_hprot), .src_hmastlock(src_hmastlock),
    .src_hwdata(src_hwdata), .src_hrdata(src_hrdata), .src_hexcl(src_hexcl), .src_hmaster(src_hmaster),
    .src_hexokay(src_hexokay),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans), .dst_hsize(dst_hsize),
    .dst_hburst(dst_hburst), .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock),
    .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  // Single upstream master: arbiter HREADY is the monitor's own HREADYOUT
  assign src_hready = src_hready_resp;

  function automatic logic [7:0] mem_idx(input logic [31:0] a);
    return {a[13:12], a[7:2]};
  endfunction

  // Slave: hprot[1:0] = wait states, hprot[3] = two-cycle ERROR
  logic        s_active, s_write, s_err;
  logic [1:0]  s_wait;
  logic [7:0]  s_idx;
  logic [31:0] smem [256];

  assign dst_hready_resp = !s_active || (s_wait == 2'd0);
  assign dst_hresp       = s_active && s_err;
  assign dst_hrdata      = s_active ? smem[s_idx] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_active <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_wait <= 2'd0; s_idx <= 8'd0;
      for (int i = 0; i < 256; i++) smem[i] <= 32'h0;
    end else begin
      if (s_active) begin
        if (s_wait == 2'd0) begin
          if (s_write && !s_err) smem[s_idx] <= dst_hwdata;
          s_active <= 1'b0;
        end else begin
          s_wait <= s_wait - 2'd1;
        end
      end
      if (dst_hready && dst_htrans[1]) begin
        s_active <= 1'b1;
        s_write  <= dst_hwrite;
        s_idx    <= mem_idx(dst_haddr);
        s_err    <= dst_hprot[3];
        s_wait   <= dst_hprot[3] ? 2'd1 : dst_hprot[1:0];
      end
    end
  end

  typedef struct {
    logic [7:0]  m;
    logic        excl;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  prot;
    logic [31:0] data;
    logic        e_supp;
    logic        e_err;
    logic        e_okay;
    logic        chk_rdata;
    logic [31:0] e_rdata;
  } txn_t;

  txn_t cur[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [7:0] m, input logic excl, input logic wr, input logic [31:0] addr,
                              input logic [3:0] prot, input logic [31:0] data, input logic supp,
                              input logic err, input logic okay, input logic chk, input logic [31:0] rdata);
    txn_t t;
    t.m = m; t.excl = excl; t.wr = wr; t.addr = addr; t.prot = prot; t.data = data;
    t.e_supp = supp; t.e_err = err; t.e_okay = okay; t.chk_rdata = chk; t.e_rdata = rdata;
    return t;
  endfunction

  // Transaction-level reference: forwarding makes the pipelined stream equivalent to sequential execution
  logic        mv [N_M];
  logic [28:0] mg [N_M];
  logic [31:0] mm [256];

  function automatic void reset_model();
    for (int i = 0; i < int'(N_M); i++) begin mv[i] = 1'b0; mg[i] = 29'd0; end
    for (int i = 0; i < 256; i++) mm[i] = 32'h0;
  endfunction

  function automatic txn_t predict(input txn_t t);
    txn_t        r;
    logic [28:0] g;
    logic        m_ok, pass;
    logic [7:0]  ix;
    r = t;
    g = t.addr[31:3];
    m_ok = t.m < 8'(N_M);
    ix = mem_idx(t.addr);
    if (t.excl && t.wr) pass = m_ok ? (mv[t.m[0]] && (mg[t.m[0]] == g)) : 1'b0;
    else pass = m_ok;
    r.e_supp = t.excl && t.wr && !pass;
    r.e_err = !r.e_supp && t.prot[3];
    r.e_okay = t.excl && pass && !r.e_err;
    r.chk_rdata = !t.wr && !r.e_err;
    r.e_rdata = mm[ix];
    if (t.excl && !t.wr && m_ok && !r.e_err) begin mv[t.m[0]] = 1'b1; mg[t.m[0]] = g; end
    if (t.excl && t.wr && m_ok) mv[t.m[0]] = 1'b0;
    for (int i = 0; i < int'(N_M); i++) begin
      if (mg[i] == g && t.wr && !r.e_err && !r.e_supp && (!t.excl || pass) && (t.excl || SNOOP)) mv[i] = 1'b0;
    end
    if (t.wr && !r.e_supp && !r.e_err) mm[ix] = t.data;
    return r;
  endfunction

  task automatic drive_idle();
    src_htrans = 2'b00; src_hexcl = 1'b0; src_hwrite = 1'b0; src_haddr = 32'h0;
    src_hmaster = 8'd0; src_hprot = 4'h0; src_hsize = 3'd2; src_hburst = 3'd0; src_hmastlock = 1'b0;
  endtask

  task automatic drive_addr(input txn_t t);
    src_htrans = 2'b10; src_hexcl = t.excl; src_hwrite = t.wr; src_haddr = t.addr;
    src_hmaster = t.m; src_hprot = t.prot; src_hsize = 3'd2; src_hburst = 3'd0; src_hmastlock = 1'b0;
  endtask

  // Back-to-back pipelined issue of cur[], checking address and data phases
  task automatic run_stream();
    int   nxt = 0, dp = -1, cyc = 0, dpc = 0, exp_cyc;
    logic ph_resp = 1'b0, ph_rdy = 1'b1;
    while ((nxt < cur.size() || dp >= 0) && cyc < LIMIT) begin
      if (nxt < cur.size()) drive_addr(cur[nxt]); else drive_idle();
      src_hwdata = (dp >= 0 && cur[dp].wr) ? cur[dp].data : 32'h0;
      @(negedge clk);
      if (src_hready) begin
        if (nxt < cur.size()) check("dst_htrans", 32'(dst_htrans), cur[nxt].e_supp ? 32'd0 : 32'd2);
        if (dp >= 0) begin
          check("src_hresp", 32'(src_hresp), 32'(cur[dp].e_err));
          check("src_hexokay", 32'(src_hexokay), 32'(cur[dp].e_okay));
          if (cur[dp].chk_rdata) check("src_hrdata", src_hrdata, cur[dp].e_rdata);
          exp_cyc = cur[dp].e_supp ? 1 : (cur[dp].e_err ? 2 : int'(cur[dp].prot[1:0]) + 1);
          check("dp_cycles", 32'(dpc + 1), 32'(exp_cyc));
          if (cur[dp].e_err) check("err_cycle1", 32'({ph_rdy, ph_resp}), 32'd1);
        end
      end
      ph_resp = src_hresp;
      ph_rdy  = src_hready;
      @(posedge clk); #1;
      cyc++;
      if (ph_rdy) begin
        if (nxt < cur.size()) begin dp = nxt; nxt++; end else dp = -1;
        dpc = 0;
      end else begin
        dpc++;
      end
    end
    if (cyc >= LIMIT) begin
      n_chk++; n_fail++;
      $display("FAIL stream_timeout: got %0d cycles required below %0d", cyc, LIMIT);
    end
    drive_idle();
    cur.delete();
  endtask

  initial begin
    txn_t t;
    int   r;
    rst_n = 1'b0;
    drive_idle();
    src_hwdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hready_resp", 32'(src_hready_resp), 32'd1);
    check("rst_hresp", 32'(src_hresp), 32'd0);
    check("rst_hexokay", 32'(src_hexokay), 32'd0);
    check("rst_dst_htrans", 32'(dst_htrans), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // m, excl, wr, addr, prot, data, supp, err, okay, chk_rdata, rdata
    cur.push_back(mk(0, 1, 0, 32'h1000, 4'h0, 32'h0,  0, 0, 1, 1, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h1004, 4'h1, 32'hA5, 0, 0, 1, 0, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h1000, 4'h0, 32'h11, 1, 0, 0, 0, 32'h0));
    cur.push_back(mk(0, 0, 0, 32'h1004, 4'h2, 32'h0,  0, 0, 0, 1, 32'hA5));
    cur.push_back(mk(0, 1, 1, 32'h2000, 4'h0, 32'hDEAD, 1, 0, 0, 0, 32'h0));
    cur.push_back(mk(0, 0, 0, 32'h2000, 4'h0, 32'h0,  0, 0, 0, 1, 32'h0));
    cur.push_back(mk(0, 1, 0, 32'h3000, 4'h0, 32'h0,  0, 0, 1, 1, 32'h0));
    cur.push_back(mk(1, 1, 0, 32'h3000, 4'h3, 32'h0,  0, 0, 1, 1, 32'h0));
    cur.push_back(mk(1, 1, 1, 32'h3000, 4'h0, 32'h33, 0, 0, 1, 0, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h3000, 4'h0, 32'h44, 1, 0, 0, 0, 32'h0));
    cur.push_back(mk(0, 0, 0, 32'h3000, 4'h0, 32'h0,  0, 0, 0, 1, 32'h33));
    cur.push_back(mk(0, 1, 0, 32'h4000, 4'h0, 32'h0,  0, 0, 1, 1, 32'h0));
    cur.push_back(mk(1, 0, 1, 32'h4004, 4'h0, 32'h55, 0, 0, 0, 0, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h4000, 4'h0, 32'h66, SNOOP, 0, !SNOOP, 0, 32'h0));
    cur.push_back(mk(5, 1, 0, 32'h1000, 4'h0, 32'h0,  0, 0, 0, 1, 32'h0));
    cur.push_back(mk(1, 1, 1, 32'h1000, 4'h0, 32'h77, 1, 0, 0, 0, 32'h0));
    cur.push_back(mk(5, 1, 1, 32'h1000, 4'h0, 32'h88, 1, 0, 0, 0, 32'h0));
    cur.push_back(mk(0, 1, 0, 32'h5008, 4'h0, 32'h0,  0, 0, 1, 0, 32'h0));
    cur.push_back(mk(0, 1, 0, 32'h5000, 4'h8, 32'h0,  0, 1, 0, 0, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h5008, 4'h0, 32'h99, 0, 0, 1, 0, 32'h0));
    cur.push_back(mk(0, 1, 1, 32'h5000, 4'h0, 32'h9A, 1, 0, 0, 0, 32'h0));
    run_stream();

    // Reset in the middle of a wait-stated data phase after a reservation
    cur.push_back(mk(0, 1, 0, 32'h6000, 4'h0, 32'h0, 0, 0, 1, 1, 32'h0));
    run_stream();
    t = mk(0, 0, 0, 32'h6000, 4'h3, 32'h0, 0, 0, 0, 0, 32'h0);
    drive_addr(t);
    @(negedge clk);
    check("mid_accept_hready", 32'(src_hready), 32'd1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("mid_dp_wait", 32'(src_hready_resp), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hready_resp", 32'(src_hready_resp), 32'd1);
    check("mid_rst_hresp", 32'(src_hresp), 32'd0);
    check("mid_rst_hexokay", 32'(src_hexokay), 32'd0);
    check("mid_rst_dst_htrans", 32'(dst_htrans), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cur.push_back(mk(0, 1, 1, 32'h6000, 4'h0, 32'hBB, 1, 0, 0, 0, 32'h0));
    run_stream();

    // Randomized streams against the transaction model (slave memory was cleared by reset)
    reset_model();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 200; k++) begin
        r = $urandom_range(0, 9);
        t.m = (r < 5) ? 8'd0 : ((r < 9) ? 8'd1 : 8'd5);
        t.excl = $urandom_range(0, 99) < 60;
        t.wr = $urandom_range(0, 1) == 1;
        r = $urandom_range(0, 3);
        t.addr = (r == 0) ? 32'h1000 : ((r == 1) ? 32'h1008 : ((r == 2) ? 32'h2000 : 32'h3010));
        t.addr = t.addr + 32'($urandom_range(0, 1) * 4);
        t.prot = {($urandom_range(0, 11) == 0), 1'b0, 2'($urandom_range(0, 3))};
        t.data = $urandom;
        cur.push_back(predict(t));
      end
      run_stream();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
